// File: rtl/sap_cpu_pkg.sv
// Shared opcode encodings and controller state type for the SAP accumulator core.
package sap_cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    PROG,
    FETCH,
    EXEC,
    HALT
  } state_e;

endpackage

// File: rtl/sap_cpu_ram.sv
// Unified program/data RAM: one synchronous write port, one combinational read port,
// whole array cleared asynchronously on reset.
module sap_cpu_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read sees the pre-write contents when addresses collide.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sap_cpu_core.sv
// Accumulator CPU core: program loader (valid/ready), 2-cycle fetch/execute,
// conditional jumps on carry/zero, and halt with re-entry into program load.
module sap_cpu_core
  import sap_cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_mode,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic              prog_done,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted,
  output logic              cf,
  output logic              zf
);

  localparam int OPND_W = DATA_W - 4;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, wptr_q, wptr_d;
  logic [DATA_W-1:0] a_q, a_d, ir_q, ir_d, out_q, out_d;
  logic              cf_q, cf_d, zf_q, zf_d, ov_q, ov_d, done_q, done_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  logic [DATA_W:0]   alu;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] addr;

  assign opcode = ir_q[DATA_W-1:DATA_W-4];
  assign addr   = ir_q[ADDR_W-1:0];

  sap_cpu_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk    (clk),
    .rst    (rst),
    .we_i   (ram_we),
    .waddr_i(ram_waddr),
    .wdata_i(ram_wdata),
    .raddr_i(ram_raddr),
    .rdata_o(ram_rdata)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    wptr_d    = wptr_q;
    a_d       = a_q;
    ir_d      = ir_q;
    out_d     = out_q;
    cf_d      = cf_q;
    zf_d      = zf_q;
    ov_d      = 1'b0;
    done_d    = done_q;
    ram_we    = 1'b0;
    ram_waddr = wptr_q;
    ram_wdata = prog_data;
    ram_raddr = pc_q;
    alu       = '0;

    case (state_q)
      IDLE: state_d = prog_mode ? PROG : FETCH;

      PROG: begin
        if (prog_valid && prog_ready) begin
          ram_we = 1'b1;
          wptr_d = wptr_q + 1'b1;
          if (wptr_q == '1) done_d = 1'b1;
        end
        if (!prog_mode) begin
          state_d = FETCH;
          pc_d    = '0;
          a_d     = '0;
          cf_d    = 1'b0;
          zf_d    = 1'b0;
        end
      end

      FETCH: begin
        ir_d    = ram_rdata;
        pc_d    = pc_q + 1'b1;
        state_d = EXEC;
      end

      EXEC: begin
        ram_raddr = addr;
        state_d   = FETCH;
        case (opcode)
          OP_LDA: a_d = ram_rdata;
          OP_ADD: begin
            alu  = {1'b0, a_q} + {1'b0, ram_rdata};
            a_d  = alu[DATA_W-1:0];
            cf_d = alu[DATA_W];
            zf_d = (alu[DATA_W-1:0] == '0);
          end
          // Two's-complement subtract: carry out set means no borrow.
          OP_SUB: begin
            alu  = {1'b0, a_q} + {1'b0, ~ram_rdata} + {{DATA_W{1'b0}}, 1'b1};
            a_d  = alu[DATA_W-1:0];
            cf_d = alu[DATA_W];
            zf_d = (alu[DATA_W-1:0] == '0);
          end
          OP_STA: begin
            ram_we    = 1'b1;
            ram_waddr = addr;
            ram_wdata = a_q;
          end
          OP_LDI: a_d = {4'b0000, ir_q[OPND_W-1:0]};
          OP_JMP: pc_d = addr;
          OP_JC:  if (cf_q) pc_d = addr;
          OP_JZ:  if (zf_q) pc_d = addr;
          OP_OUT: begin
            out_d = a_q;
            ov_d  = 1'b1;
          end
          OP_HLT: state_d = HALT;
          default: ;
        endcase
      end

      HALT: begin
        if (prog_mode) begin
          state_d = PROG;
          wptr_d  = '0;
          done_d  = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      wptr_q  <= '0;
      a_q     <= '0;
      ir_q    <= '0;
      out_q   <= '0;
      cf_q    <= 1'b0;
      zf_q    <= 1'b0;
      ov_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wptr_q  <= wptr_d;
      a_q     <= a_d;
      ir_q    <= ir_d;
      out_q   <= out_d;
      cf_q    <= cf_d;
      zf_q    <= zf_d;
      ov_q    <= ov_d;
      done_q  <= done_d;
    end
  end

  assign prog_ready = (state_q == PROG) && !done_q;
  assign prog_done  = done_q;
  assign out_data   = out_q;
  assign out_valid  = ov_q;
  assign halted     = (state_q == HALT);
  assign cf         = cf_q;
  assign zf         = zf_q;

endmodule
